// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR key controller: FSM state encoding, key code
// constants and the NEC command bytes produced by the remote.
// ---------------------------------------------------------------------------
package ir_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    localparam logic [3:0] KEY_CLR = 4'd10;
    localparam logic [3:0] KEY_ENT = 4'd11;

    localparam logic [7:0] NEC_0   = 8'h16;
    localparam logic [7:0] NEC_1   = 8'h0C;
    localparam logic [7:0] NEC_2   = 8'h18;
    localparam logic [7:0] NEC_3   = 8'h5E;
    localparam logic [7:0] NEC_4   = 8'h08;
    localparam logic [7:0] NEC_5   = 8'h1C;
    localparam logic [7:0] NEC_6   = 8'h5A;
    localparam logic [7:0] NEC_7   = 8'h42;
    localparam logic [7:0] NEC_8   = 8'h52;
    localparam logic [7:0] NEC_9   = 8'h4A;
    localparam logic [7:0] NEC_CLR = 8'h45;
    localparam logic [7:0] NEC_ENT = 8'h40;

endpackage

// File: rtl/ir_key_map.sv
// ---------------------------------------------------------------------------
// ir_key_map
// Combinational NEC frame validation and command-to-key translation.
// Ports:
//   frame  in  32  NEC frame {addr, ~addr, cmd, ~cmd}
//   valid  out 1   complements match, address matches P_ADDR, cmd is mapped
//   key    out 4   key code (0-9 digit, KEY_CLR, KEY_ENT); 0 when unmapped
// ---------------------------------------------------------------------------
module ir_key_map
    import ir_pkg::*;
#(
    parameter logic [7:0] P_ADDR = 8'h00
) (
    input  logic [31:0] frame,
    output logic        valid,
    output logic [3:0]  key
);

    logic [7:0] addr;
    logic [7:0] addr_n;
    logic [7:0] cmd;
    logic [7:0] cmd_n;
    logic       mapped;

    assign addr   = frame[31:24];
    assign addr_n = frame[23:16];
    assign cmd    = frame[15:8];
    assign cmd_n  = frame[7:0];

    always_comb begin
        key    = 4'd0;
        mapped = 1'b1;
        case (cmd)
            NEC_0:   key = 4'd0;
            NEC_1:   key = 4'd1;
            NEC_2:   key = 4'd2;
            NEC_3:   key = 4'd3;
            NEC_4:   key = 4'd4;
            NEC_5:   key = 4'd5;
            NEC_6:   key = 4'd6;
            NEC_7:   key = 4'd7;
            NEC_8:   key = 4'd8;
            NEC_9:   key = 4'd9;
            NEC_CLR: key = KEY_CLR;
            NEC_ENT: key = KEY_ENT;
            default: mapped = 1'b0;
        endcase
    end

    assign valid = (addr == ~addr_n) && (cmd == ~cmd_n) && (addr == P_ADDR) && mapped;

endmodule

// File: rtl/ir_key_ctrl.sv
// ---------------------------------------------------------------------------
// ir_key_ctrl
// Takes NEC frames from the IR receiver, validates and maps them to key codes
// and sequences a six-digit BCD entry buffer (digit entry, CLEAR, ENTER).
// Optional feature macro: IR_KEY_REPEAT_EN (NEC repeat codes re-issue the
// last key within a P_REPEAT_TO-cycle window).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_frame      NEC frame, sampled when i_frame_vld is high
//   i_frame_vld  one-cycle frame strobe
//   i_repeat     one-cycle NEC repeat strobe
//   o_key        key code, qualified by o_key_vld
//   o_key_vld    one-cycle key strobe (APPLY cycle)
//   o_entry      six BCD digits being typed, [3:0] rightmost
//   o_value      last entered value
//   o_value_vld  one-cycle strobe on ENTER, aligned with o_key_vld
//   o_busy       FSM not idle
//   o_err_cnt    saturating count of rejected and dropped frames
// ---------------------------------------------------------------------------
module ir_key_ctrl
    import ir_pkg::*;
#(
    parameter logic [7:0]  P_ADDR      = 8'h00,
    parameter logic [31:0] P_REPEAT_TO = 32'd5_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_repeat,
    output logic [3:0]  o_key,
    output logic        o_key_vld,
    output logic [23:0] o_entry,
    output logic [23:0] o_value,
    output logic        o_value_vld,
    output logic        o_busy,
    output logic [7:0]  o_err_cnt
);

    state_t      state;
    logic [31:0] frame_q;
    logic        map_valid;
    logic [3:0]  map_key;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;
    logic [7:0]  err_next;

`ifdef IR_KEY_REPEAT_EN
    logic [31:0] timer;
    logic [3:0]  last_key;
    logic        has_last;
`else
    logic        unused_cfg;
    assign unused_cfg = ^{i_repeat, P_REPEAT_TO};
`endif

    ir_key_map #(
        .P_ADDR(P_ADDR)
    ) u_map (
        .frame(frame_q),
        .valid(map_valid),
        .key  (map_key)
    );

    // A rejected frame in CHECK and a dropped frame arriving in the same
    // cycle both count, so the increment can be two.
    always_comb begin
        err_inc = 2'd0;
        if (state == S_CHECK && !map_valid) begin
            err_inc = err_inc + 2'd1;
        end
        if (i_frame_vld && state != S_IDLE) begin
            err_inc = err_inc + 2'd1;
        end
        err_sum  = {1'b0, o_err_cnt} + {7'd0, err_inc};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            frame_q     <= 32'd0;
            o_key       <= 4'd0;
            o_key_vld   <= 1'b0;
            o_entry     <= 24'd0;
            o_value     <= 24'd0;
            o_value_vld <= 1'b0;
            o_busy      <= 1'b0;
            o_err_cnt   <= 8'd0;
`ifdef IR_KEY_REPEAT_EN
            timer       <= 32'd0;
            last_key    <= 4'd0;
            has_last    <= 1'b0;
`endif
        end else begin
            o_key_vld   <= 1'b0;
            o_value_vld <= 1'b0;
            o_err_cnt   <= err_next;
`ifdef IR_KEY_REPEAT_EN
            if (timer != 32'd0) begin
                timer <= timer - 32'd1;
            end
`endif
            case (state)
                S_IDLE: begin
                    // A frame takes priority over a simultaneous repeat.
                    if (i_frame_vld) begin
                        frame_q <= i_frame;
                        state   <= S_CHECK;
                        o_busy  <= 1'b1;
                    end
`ifdef IR_KEY_REPEAT_EN
                    else if (i_repeat && timer != 32'd0 && has_last) begin
                        o_key       <= last_key;
                        o_key_vld   <= 1'b1;
                        o_value_vld <= (last_key == KEY_ENT);
                        state       <= S_APPLY;
                        o_busy      <= 1'b1;
                    end
`endif
                end
                S_CHECK: begin
                    if (map_valid) begin
                        o_key       <= map_key;
                        o_key_vld   <= 1'b1;
                        o_value_vld <= (map_key == KEY_ENT);
                        state       <= S_APPLY;
                    end else begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                S_APPLY: begin
                    // o_key already holds the key being applied.
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    if (o_key == KEY_CLR) begin
                        o_entry <= 24'd0;
                    end else if (o_key == KEY_ENT) begin
                        o_value <= o_entry;
                        o_entry <= 24'd0;
                    end else begin
                        o_entry <= {o_entry[19:0], o_key};
                    end
`ifdef IR_KEY_REPEAT_EN
                    timer    <= P_REPEAT_TO;
                    last_key <= o_key;
                    has_last <= 1'b1;
`endif
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_key_ctrl
// Self-checking bench for ir_key_ctrl: directed scenarios plus randomized
// frames compared against a behavioural model of the entry buffer, stored
// value, error counter and repeat window.
// ---------------------------------------------------------------------------
module tb_ir_key_ctrl;

    localparam logic [31:0] T_REP = 32'd2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_frame;
    logic        i_frame_vld;
    logic        i_repeat;
    logic [3:0]  o_key;
    logic        o_key_vld;
    logic [23:0] o_entry;
    logic [23:0] o_value;
    logic        o_value_vld;
    logic        o_busy;
    logic [7:0]  o_err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state
    logic [23:0] m_entry;
    logic [23:0] m_value;
    int          m_err;
    int          m_last_key;
    int          m_last_apply;
    logic [7:0]  cmd_tab [12];

    ir_key_ctrl #(
        .P_ADDR     (8'h00),
        .P_REPEAT_TO(T_REP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_frame    (i_frame),
        .i_frame_vld(i_frame_vld),
        .i_repeat   (i_repeat),
        .o_key      (o_key),
        .o_key_vld  (o_key_vld),
        .o_entry    (o_entry),
        .o_value    (o_value),
        .o_value_vld(o_value_vld),
        .o_busy     (o_busy),
        .o_err_cnt  (o_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk_frame(input logic [7:0] cmd);
        return {8'h00, 8'hFF, cmd, ~cmd};
    endfunction

    // Key index for a frame, or -1 when the frame must be rejected.
    function automatic int ref_key(input logic [31:0] f);
        logic [7:0] a, an, c, cn;
        a = f[31:24]; an = f[23:16]; c = f[15:8]; cn = f[7:0];
        if (a != 8'h00 || an != ~a || cn != ~c) return -1;
        for (int k = 0; k < 12; k++) begin
            if (cmd_tab[k] == c) return k;
        end
        return -1;
    endfunction

    function automatic void model_apply(input int k);
        logic [3:0] d;
        d = k[3:0];
        if (k < 10) m_entry = {m_entry[19:0], d};
        else if (k == 10) m_entry = 24'd0;
        else begin
            m_value = m_entry;
            m_entry = 24'd0;
        end
        m_last_key = k;
    endfunction

    function automatic void model_err();
        m_err = (m_err >= 255) ? 255 : m_err + 1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        i_frame_vld = 1'b0;
        i_repeat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_entry = 24'd0;
        m_value = 24'd0;
        m_err = 0;
        m_last_key = -1;
        m_last_apply = 0;
    endtask

    // Drives one frame at cycle N and checks N+1, N+2 and N+3 against the model.
    task automatic run_frame(input logic [31:0] f);
        int k;
        k = ref_key(f);
        @(posedge clk); #1;
        i_frame = f;
        i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        i_frame = $urandom;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_check_cycle: got %0b expected 1 (frame %h)", o_busy, f);
        end
        @(posedge clk); #1;
        checks++;
        if (o_key_vld !== (k >= 0)) begin
            errors++;
            $display("[TB] FAIL key_vld: got %0b expected %0b (frame %h)", o_key_vld, (k >= 0), f);
        end
        if (k >= 0) begin
            checks++;
            if (o_key !== 4'(k)) begin
                errors++;
                $display("[TB] FAIL key: got %0d expected %0d (frame %h)", o_key, k, f);
            end
            m_last_apply = cyc;
        end else begin
            model_err();
        end
        checks++;
        if (o_value_vld !== (k == 11)) begin
            errors++;
            $display("[TB] FAIL value_vld: got %0b expected %0b (frame %h)", o_value_vld, (k == 11), f);
        end
        @(posedge clk); #1;
        if (k >= 0) model_apply(k);
        checks++;
        if (o_entry !== m_entry || o_value !== m_value || o_err_cnt !== 8'(m_err) || o_key_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL state_after: entry %h value %h err %0d kv %0b, expected entry %h value %h err %0d kv 0",
                     o_entry, o_value, o_err_cnt, o_key_vld, m_entry, m_value, m_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_frame = 32'd0;
        i_frame_vld = 1'b0;
        i_repeat = 1'b0;
        #3;
        checks++;
        if ({o_key, o_key_vld, o_entry, o_value, o_value_vld, o_busy, o_err_cnt} !== 63'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got key %0d kv %0b entry %h value %h vv %0b busy %0b err %0d, expected all 0",
                     o_key, o_key_vld, o_entry, o_value, o_value_vld, o_busy, o_err_cnt);
        end
        apply_reset();
    endtask

    task automatic test_single_digit();
        run_frame(32'h00FF_0CF3);
        checks++;
        if (o_entry !== 24'h000001) begin
            errors++;
            $display("[TB] FAIL single_digit_entry: got %h expected 000001", o_entry);
        end
    endtask

    task automatic test_digits_enter();
        for (int d = 1; d <= 7; d++) run_frame(mk_frame(cmd_tab[d]));
        checks++;
        if (o_entry !== 24'h234567) begin
            errors++;
            $display("[TB] FAIL overflow_entry: got %h expected 234567", o_entry);
        end
        run_frame(32'h00FF_40BF);
        checks++;
        if (o_value !== 24'h234567 || o_entry !== 24'h000000) begin
            errors++;
            $display("[TB] FAIL enter_value: got value %h entry %h expected 234567 / 000000", o_value, o_entry);
        end
    endtask

    task automatic test_bad_frames();
        logic [7:0] c;
        logic [7:0] x;
        apply_reset();
        run_frame(32'h00FF_0C0C);
        run_frame(32'h01FE_0CF3);
        checks++;
        if (o_err_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL err_cnt_two: got %0d expected 2", o_err_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            c = 8'($urandom);
            x = 8'($urandom_range(1, 255));
            run_frame({8'h00, 8'hFF, c, ~c ^ x});
        end
        checks++;
        if (o_err_cnt !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL err_cnt_saturate: got %h expected FF", o_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int ka;
        apply_reset();
        ka = $urandom_range(0, 9);
        @(posedge clk); #1;
        i_frame = mk_frame(cmd_tab[ka]);
        i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame = mk_frame(cmd_tab[$urandom_range(0, 9)]);
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        model_err();
        checks++;
        if (o_key_vld !== 1'b1 || o_key !== 4'(ka)) begin
            errors++;
            $display("[TB] FAIL b2b_key: got kv %0b key %0d expected kv 1 key %0d", o_key_vld, o_key, ka);
        end
        m_last_apply = cyc;
        @(posedge clk); #1;
        model_apply(ka);
        checks++;
        if (o_entry !== m_entry || o_err_cnt !== 8'(m_err)) begin
            errors++;
            $display("[TB] FAIL b2b_after: got entry %h err %0d expected entry %h err %0d", o_entry, o_err_cnt, m_entry, m_err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_key_vld !== 1'b0 || o_entry !== m_entry) begin
            errors++;
            $display("[TB] FAIL b2b_dropped: got kv %0b entry %h expected kv 0 entry %h", o_key_vld, o_entry, m_entry);
        end
    endtask

    // Repeat pulse issued 'delay' cycles after the most recent APPLY cycle.
    task automatic repeat_at(input int delay);
        bit honour;
        int target;
        target = m_last_apply + delay;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
`ifdef IR_KEY_REPEAT_EN
        honour = (m_last_key >= 0) && (delay <= int'(T_REP));
`else
        honour = 1'b0;
`endif
        i_repeat = 1'b1;
        @(posedge clk); #1;
        i_repeat = 1'b0;
        checks++;
        if (o_key_vld !== honour) begin
            errors++;
            $display("[TB] FAIL repeat_key_vld: got %0b expected %0b (delay %0d)", o_key_vld, honour, delay);
        end
        if (honour) begin
            checks++;
            if (o_key !== 4'(m_last_key)) begin
                errors++;
                $display("[TB] FAIL repeat_key: got %0d expected %0d", o_key, m_last_key);
            end
            m_last_apply = cyc;
        end
        @(posedge clk); #1;
        if (honour) model_apply(m_last_key);
        checks++;
        if (o_entry !== m_entry || o_err_cnt !== 8'(m_err)) begin
            errors++;
            $display("[TB] FAIL repeat_after: got entry %h err %0d expected entry %h err %0d", o_entry, o_err_cnt, m_entry, m_err);
        end
    endtask

    task automatic test_repeat();
        apply_reset();
        run_frame(mk_frame(8'h1C));
        repeat_at(1000);
`ifdef IR_KEY_REPEAT_EN
        checks++;
        if (o_entry !== 24'h000055) begin
            errors++;
            $display("[TB] FAIL repeat_entry: got %h expected 000055", o_entry);
        end
`endif
        repeat_at(int'(T_REP) + 10);
    endtask

    task automatic test_random();
        logic [31:0] f;
        logic [7:0]  c;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0, 1: f = mk_frame(cmd_tab[$urandom_range(0, 11)]);
                2: begin
                    c = 8'($urandom);
                    f = {8'h00, 8'hFF, c, ~c ^ 8'($urandom_range(1, 255))};
                end
                default: f = $urandom;
            endcase
            run_frame(f);
            if ($urandom_range(0, 3) == 0) repeat_at($urandom_range(3, 40));
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        run_frame(mk_frame(cmd_tab[3]));
        @(posedge clk); #1;
        i_frame = mk_frame(cmd_tab[7]);
        i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_key, o_key_vld, o_entry, o_value, o_value_vld, o_busy, o_err_cnt} !== 63'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got key %0d kv %0b entry %h value %h vv %0b busy %0b err %0d, expected all 0",
                     o_key, o_key_vld, o_entry, o_value, o_value_vld, o_busy, o_err_cnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b1;
            if (o_key_vld) seen = 1'b1;
        end
        checks++;
        if (seen || o_entry !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pulse: got kv_seen %0b entry %h expected 0 / 000000", seen, o_entry);
        end
        m_entry = 24'd0;
        m_value = 24'd0;
        m_err = 0;
        m_last_key = -1;
    endtask

    initial begin
        cmd_tab = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08, 8'h1C,
                    8'h5A, 8'h42, 8'h52, 8'h4A, 8'h45, 8'h40};
        test_reset();
        test_single_digit();
        test_digits_enter();
        test_bad_frames();
        test_back_to_back();
        test_repeat();
        apply_reset();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_key_ctrl.md
# ir_key_ctrl

Command controller between the IR receiver and the six-digit LED display path. It takes completed 32-bit NEC frames from the IR receiver and validates the address and command complements. Valid frames are mapped to key codes, and a six-digit BCD entry buffer is sequenced (digit entry, clear, enter). Its BCD outputs feed the `fnd_dec`/`led_disp` chain in the top level.

## Interface
Parameters:
- `P_ADDR`, 8'h00, required NEC custom (address) byte.
- `P_REPEAT_TO`, 32'd5_500_000, repeat-window length in clk cycles (110 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_frame`  in  32  NEC frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- `i_frame_vld`  in  1  one-cycle pulse, `i_frame` stable that cycle.
- `i_repeat`  in  1  one-cycle pulse, NEC repeat code detected.
- `o_key`  out  4  key code: 0–9 digit, 10 CLEAR, 11 ENTER.
- `o_key_vld`  out  1  one-cycle pulse, `o_key` valid.
- `o_entry`  out  24  six BCD digits being typed; [3:0] is the rightmost digit.
- `o_value`  out  24  last entered six-digit BCD value.
- `o_value_vld`  out  1  one-cycle pulse on ENTER.
- `o_busy`  out  1  high when FSM is not IDLE.
- `o_err_cnt`  out  8  saturating count of rejected and dropped frames.

## Operation
- FSM states: IDLE, CHECK, APPLY.
  - IDLE → CHECK on `i_frame_vld`, capturing `i_frame`.
  - CHECK → APPLY if the frame is valid and mapped; otherwise CHECK → IDLE and `o_err_cnt` increments.
  - APPLY → IDLE always.
- Frame valid when all hold: addr == ~addr_n, cmd == ~cmd_n, addr == `P_ADDR`.
- Command map (NEC codes):
  - Digits 0–9: 0x16, 0x0C, 0x18, 0x5E, 0x08, 0x1C, 0x5A, 0x42, 0x52, 0x4A.
  - CLEAR: 0x45. ENTER: 0x40.
  - Any other cmd counts as an error.
- APPLY actions (all in one cycle): `o_key`/`o_key_vld` asserted, last key stored, repeat timer loaded with `P_REPEAT_TO`.
  - Digit d: `o_entry` <= {`o_entry`[19:0], d}. The top digit is discarded on overflow.
  - CLEAR: `o_entry` <= 0.
  - ENTER: `o_value` <= `o_entry`, `o_entry` <= 0, `o_value_vld` pulses in the same cycle as `o_key_vld`.
- `i_frame_vld` while `o_busy`: frame dropped, `o_err_cnt` increments.
- `o_err_cnt` saturates at 8'hFF; no wrap.
- `i_frame_vld` and `i_repeat` in the same IDLE cycle: the frame wins and the repeat is ignored without counting.
- Repeat timer decrements to 0 and holds there. A repeat is honoured only when the timer is nonzero and a last key exists.

## Timing
- Reset: all outputs 0, FSM IDLE, timer 0, no last key.
- `i_frame_vld` at cycle N → CHECK at N+1 → APPLY at N+2: `o_key_vld` (and `o_value_vld`) high at N+2, and `o_entry`/`o_value` updated from N+3.
- Repeat (when enabled): `i_repeat` in IDLE at N → APPLY at N+1 with the last key, i.e. one cycle latency.
- `o_busy` is high in cycles N+1 and N+2.
- Reset mid-operation: immediate return to the reset state; no pulse is emitted.

## Configuration
- `IR_KEY_REPEAT_EN` defined:
  - `i_repeat` within the window re-issues the last key through APPLY, with full digit/CLEAR/ENTER effect.
  - The timer reloads on every APPLY.
  - A repeat with an expired timer or no last key is ignored and not counted.
- `IR_KEY_REPEAT_EN` undefined:
  - `i_repeat` is ignored; the port remains.
  - Repeat timer and last-key storage are not built.

## Structure
- Shared package `ir_pkg` holds:
  - FSM state encoding.
  - Key code constants (KEY_CLR = 4'd10, KEY_ENT = 4'd11).
  - NEC command byte constants.
- One sub-module, `ir_key_map`: combinational validity check plus cmd → key mapping, with outputs `valid` and `key`.

## Test plan
- Frame 32'h00FF_0CF3 (addr 00, cmd 0x0C) → `o_key_vld` at N+2 with `o_key` = 1; `o_entry` = 24'h000001.
- Digits 1,2,3,4,5,6,7 → `o_entry` = 24'h234567 (top digit dropped). Then ENTER (32'h00FF_40BF) → `o_value` = 24'h234567, `o_value_vld` pulses, `o_entry` = 0.
- Bad complement 32'h00FF_0C0C and wrong addr 32'h01FE_0CF3 → no `o_key_vld`; `o_err_cnt` = 2. Then 300 bad frames → `o_err_cnt` stays 8'hFF.
- Second `i_frame_vld` one cycle after the first → first frame processed, second dropped, `o_err_cnt` +1.
- With `IR_KEY_REPEAT_EN`:
  - digit 5, then `i_repeat` 1000 cycles later → second key 5, `o_entry` = 24'h000055.
  - `i_repeat` at `P_REPEAT_TO` + 10 cycles → ignored.
  - Without the macro: repeat never produces a key.
- Assert `rst_n` low at cycle N+1 of a valid frame → no `o_key_vld`; all outputs 0.
